// File: rtl/mux16_rr_scheduler_pkg.sv
// Shared definitions for the 16-way round-robin bit-mux scheduler.
//   N / SEL_W : requester count and select width
//   state_t   : scheduler FSM encoding (IDLE = nothing presented, HOLD = bit presented)
//   rr_pick   : inclusive, ascending, wrap-around search of a request vector
package mux16_rr_scheduler_pkg;

  localparam int N     = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Returns {found, index}. The search starts at 'start' (inclusive) and walks
  // upward modulo N. The index wraps naturally because it is SEL_W bits wide.
  function automatic logic [SEL_W:0] rr_pick(input logic [N-1:0]     req_vec,
                                             input logic [SEL_W-1:0] start);
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    idx   = start;
    for (int i = 0; i < N; i++) begin
      cand = start + SEL_W'(i);
      if (!found && req_vec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/mux16_rr_scheduler_mux.sv
// 16:1 single-bit multiplexer shared by all requesters.
//   in  : 16 data bits, one per requester
//   sel : index of the bit to pass through
//   y   : selected bit (purely combinational)
module mux_16by1
  import mux16_rr_scheduler_pkg::*;
(
  input  logic [N-1:0]     in,
  input  logic [SEL_W-1:0] sel,
  output logic             y
);

  assign y = in[sel];

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler sharing one 16:1 bit mux among 16 requesters.
// A requester is picked, the mux select is driven with the new grant index,
// and the selected bit is registered and presented downstream.
//   clk, rst   : clock, synchronous active-high reset
//   req        : per-requester level request
//   in         : per-requester data bit (through mux_16by1)
//   sel        : registered grant index
//   gnt        : registered one-hot grant, zero when nothing is held
//   out_data   : registered data bit captured at grant
//   out_valid  : out_data/sel/gnt are being presented
//   out_ready  : downstream accepts
//   dbg_state  : current FSM state (1 = HOLD), for observation only
//
// Handshake: a transfer completes on a rising edge where out_valid & out_ready.
// out_valid comes straight from the state register, so it never depends
// combinationally on out_ready. While out_valid is high and out_ready is low,
// sel/gnt/out_data are frozen regardless of req or in. out_ready is ignored
// while out_valid is low.
module mux16_rr_scheduler
  import mux16_rr_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     in,
  output logic [SEL_W-1:0] sel,
  output logic [N-1:0]     gnt,
  output logic             out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dbg_state
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             out_data_q, out_data_d;

  logic [SEL_W-1:0] arb_start;
  logic [SEL_W:0]   pick;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             take_grant;
  logic             mux_bit;

  // In HOLD the only arbitration that matters is the one at handshake, which
  // restarts just past the current grant; in IDLE it starts from ptr.
  assign arb_start  = (state_q == ST_HOLD) ? (sel_q + 4'd1) : ptr_q;
  assign pick       = rr_pick(req, arb_start);
  assign pick_found = pick[SEL_W];
  assign pick_idx   = pick[SEL_W-1:0];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    take_grant = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          take_grant = 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          ptr_d = sel_q + 4'd1;
          if (pick_found) begin
            take_grant = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (take_grant) begin
      state_d = ST_HOLD;
      sel_d   = pick_idx;
      gnt_d   = N'(1) << pick_idx;
    end
  end

  // The mux looks at the next select so the captured bit belongs to the new
  // grant on the same edge that the grant is registered.
  mux_16by1 u_mux (
    .in  (in),
    .sel (sel_d),
    .y   (mux_bit)
  );

  assign out_data_d = take_grant ? mux_bit : out_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      gnt_q      <= '0;
      out_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      out_data_q <= out_data_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign out_data  = out_data_q;
  assign out_valid = (state_q == ST_HOLD);
  assign dbg_state = (state_q == ST_HOLD);

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Directed bench for mux16_rr_scheduler with an expected-grant queue.
module tb_mux16_rr_scheduler;

  localparam int W = 21; // {sel[3:0], gnt[15:0], out_data}

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [15:0] in_bits;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        out_data;
  logic        out_valid;
  logic        out_ready;
  logic        dbg_state;

  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_fail;

  mux16_rr_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in        (in_bits),
    .sel       (sel),
    .gnt       (gnt),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int s, input logic [15:0] data_vec);
    logic [3:0]  s4;
    logic [15:0] g;
    s4 = 4'(s);
    g  = 16'd1 << s4;
    exp_q.push_back({s4, g, data_vec[s4]});
  endtask

  // ---------------- scoreboard monitor ----------------
  // Every presented cycle is compared with the head; the head is retired on a
  // cycle where the downstream accepts.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got sel=%0d gnt=%0h data=%0b expected none", sel, gnt, out_data);
      end else begin
        check("grant_tuple", 32'({sel, gnt, out_data}), 32'(exp_q[0]));
        if (out_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] cc;
    int          budget;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req       = '0;
    in_bits   = '0;
    out_ready = 1'b0;
    cc        = 16'hCCCC;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_sel",   32'(sel),       32'd0);
    check("reset_gnt",   32'(gnt),       32'd0);
    check("reset_data",  32'(out_data),  32'd0);
    step();

    // single requester 0
    push_exp(0, cc);
    req = 16'h0001; in_bits = cc; out_ready = 1'b1;
    step();
    req = '0;
    step();

    // reset to restart the pointer at 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst2_valid", 32'(out_valid), 32'd0);
    step();

    // full sweep 0..15,0 back-to-back
    for (int i = 0; i < 17; i++) push_exp(i % 16, cc);
    req = 16'hFFFF; in_bits = cc; out_ready = 1'b1;
    repeat (17) step();
    req = '0;
    step();
    @(negedge clk);
    check("sweep_idle", 32'(out_valid), 32'd0);
    step();

    // backpressure with two requesters (ptr now 1)
    in_bits = 16'h0004;
    push_exp(2, in_bits); push_exp(8, in_bits); push_exp(2, in_bits);
    req = 16'h0104; out_ready = 1'b0;
    repeat (4) step();
    out_ready = 1'b1;
    repeat (2) step();
    req = '0;
    step();

    // wrap 15 -> 0 -> 15 (ptr now 3)
    in_bits = 16'h8000;
    push_exp(15, in_bits); push_exp(0, in_bits); push_exp(15, in_bits);
    req = 16'h8001; out_ready = 1'b1;
    repeat (3) step();
    req = '0;
    step();

    // hold stability: req drops and data toggles while stalled
    in_bits = 16'h0020;
    push_exp(5, in_bits);
    req = 16'h0020; out_ready = 1'b0;
    step();
    req = '0; in_bits = '0;
    repeat (3) step();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    check("hold_end_valid", 32'(out_valid), 32'd0);
    check("hold_end_gnt",   32'(gnt),       32'd0);
    step();

    // reset during HOLD, coinciding with a handshake
    in_bits = 16'h0200;
    push_exp(9, in_bits);
    req = 16'h0200; out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b1; out_ready = 1'b1; req = '0;
    step();
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("midhold_rst_valid", 32'(out_valid), 32'd0);
    check("midhold_rst_gnt",   32'(gnt),       32'd0);
    step();
    in_bits = 16'h0001;
    push_exp(0, in_bits);
    req = 16'h8001; out_ready = 1'b1;
    step();
    req = '0;
    step();

    // drain
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      step();
      budget++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("final_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
